// File: rtl/mig_tt_reader.sv
// Purpose: sweeps a 4-input network through minterms 0..15 and reads y0 back into a truth table.
// Latency: done pulses 16*SETTLE_CYCLES cycles after the start edge; tt/match/mismatch_cnt update with done.
// Backpressure: none; start is only accepted in IDLE (including the done cycle), ignored while busy.
module mig_tt_reader #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] TT_EXPECTED   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        y0,
  output logic        x0,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        match,
  output logic [4:0]  mismatch_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  // Terminal value of the settle counter; the sample is taken on the edge where it is reached.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  cnt_q;
  logic [15:0] accum_q;
  logic [3:0]  x_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] tt_q;
  logic        match_q;
  logic [4:0]  mis_q;

  logic [15:0] accum_d;
  logic [15:0] diff_d;
  logic [4:0]  mis_d;
  logic        cnt_last;

  // Accumulator with the current sample merged in, plus the mismatch popcount of that value.
  // The final minterm's sample is folded in here so completion can register it in the same edge.
  always_comb begin
    accum_d         = accum_q;
    accum_d[idx_q]  = y0;
    diff_d          = accum_d ^ TT_EXPECTED;
    mis_d           = 5'd0;
    for (int i = 0; i < 16; i++) begin
      mis_d = mis_d + 5'(diff_d[i]);
    end
    cnt_last        = (cnt_q == CNT_LAST);
  end

  // Sweep controller with registered minterm drive, status and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      accum_q <= 16'h0000;
      x_q     <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= 16'h0000;
      match_q <= 1'b0;
      mis_q   <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SWEEP;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            accum_q <= 16'h0000;
            x_q     <= 4'd0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          if (cnt_last) begin
            accum_q <= accum_d;
            cnt_q   <= 4'd0;
            if (idx_q == 4'hF) begin
              // Last minterm sampled: publish results and return to IDLE in one update.
              state_q <= IDLE;
              idx_q   <= 4'd0;
              x_q     <= 4'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              tt_q    <= accum_d;
              match_q <= (accum_d == TT_EXPECTED);
              mis_q   <= mis_d;
            end else begin
              idx_q <= idx_q + 4'd1;
              x_q   <= idx_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign x0           = x_q[0];
  assign x1           = x_q[1];
  assign x2           = x_q[2];
  assign x3           = x_q[3];
  assign busy         = busy_q;
  assign done         = done_q;
  assign tt           = tt_q;
  assign match        = match_q;
  assign mismatch_cnt = mis_q;

endmodule

// File: tb/tb_mig_tt_reader.sv
// Bench for mig_tt_reader: four instances with different settle delays / expected tables,
// each driven by a behavioural network chosen per instance, checked against a truth-table model.
// Stimulus is driven on the falling edge and outputs are sampled on the falling edge.
module tb_mig_tt_reader;

  logic        clk;
  logic        rst_n;
  logic [3:0]  start_v;
  logic [3:0]  y0_v;
  logic [3:0]  x0_v, x1_v, x2_v, x3_v;
  logic [3:0]  busy_v, done_v, match_v;
  logic [15:0] tt_v [4];
  logic [4:0]  mis_v [4];
  logic [3:0]  xidx_v [4];

  int          mode [4];
  logic [15:0] rtt [4];
  int          s_of [4];
  logic [15:0] texp [4];

  int checks;
  int errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mig_tt_reader #(.SETTLE_CYCLES(1), .TT_EXPECTED(16'h8888)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .y0(y0_v[0]),
    .x0(x0_v[0]), .x1(x1_v[0]), .x2(x2_v[0]), .x3(x3_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .tt(tt_v[0]), .match(match_v[0]), .mismatch_cnt(mis_v[0]));

  mig_tt_reader #(.SETTLE_CYCLES(3), .TT_EXPECTED(16'h8888)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .y0(y0_v[1]),
    .x0(x0_v[1]), .x1(x1_v[1]), .x2(x2_v[1]), .x3(x3_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .tt(tt_v[1]), .match(match_v[1]), .mismatch_cnt(mis_v[1]));

  mig_tt_reader #(.SETTLE_CYCLES(1), .TT_EXPECTED(16'h6996)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .y0(y0_v[2]),
    .x0(x0_v[2]), .x1(x1_v[2]), .x2(x2_v[2]), .x3(x3_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .tt(tt_v[2]), .match(match_v[2]), .mismatch_cnt(mis_v[2]));

  mig_tt_reader #(.SETTLE_CYCLES(1), .TT_EXPECTED(16'h0000)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .y0(y0_v[3]),
    .x0(x0_v[3]), .x1(x1_v[3]), .x2(x2_v[3]), .x3(x3_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .tt(tt_v[3]), .match(match_v[3]), .mismatch_cnt(mis_v[3]));

  // Network under test: 0 AND(x0,x1), 1 x3, 2 XOR of all, 3 const 0, 4 const 1, else random table.
  function automatic logic model_y(input int md, input logic [3:0] m, input logic [15:0] r);
    case (md)
      0:       return m[0] & m[1];
      1:       return m[3];
      2:       return ^m;
      3:       return 1'b0;
      4:       return 1'b1;
      default: return r[m];
    endcase
  endfunction

  // Reference truth table: evaluate the network at every minterm index.
  function automatic logic [15:0] ref_tt(input int md, input logic [15:0] r);
    logic [15:0] t;
    for (int m = 0; m < 16; m++) t[m] = model_y(md, 4'(m), r);
    return t;
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      xidx_v[k] = {x3_v[k], x2_v[k], x1_v[k], x0_v[k]};
      y0_v[k]   = model_y(mode[k], xidx_v[k], rtt[k]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One sweep on instance k. With pre=1 the start was already accepted on the previous edge.
  // extra: pulse start during busy; b2b: raise start in the done cycle.
  task automatic run_and_check(input int k, input bit pre, input bit extra, input bit b2b,
                               input logic [15:0] exp_tt, input logic exp_m, input logic [4:0] exp_mis,
                               input string tag);
    int          s;
    int          lat;
    int          bcnt;
    int          xerr;
    int          ttchg;
    logic [15:0] tt0;
    s     = s_of[k];
    lat   = 0;
    bcnt  = 0;
    xerr  = 0;
    ttchg = 0;
    tt0   = tt_v[k];
    if (!pre) begin
      @(negedge clk);
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
    end
    while (!done_v[k] && lat < 16 * s + 8) begin
      if (busy_v[k]) bcnt++;
      if (int'(xidx_v[k]) != lat / s) xerr++;
      if (tt_v[k] !== tt0) ttchg++;
      start_v[k] = extra && (lat == 3 || lat == 7);
      @(negedge clk);
      lat++;
    end
    start_v[k] = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(16 * s));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(16 * s));
    chk({tag, "_x_sequence_errs"}, 32'(xerr), 32'd0);
    chk({tag, "_tt_disturbed"}, 32'(ttchg), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(busy_v[k]), 32'd0);
    chk({tag, "_x_at_done"}, 32'(xidx_v[k]), 32'd0);
    chk({tag, "_tt"}, 32'(tt_v[k]), 32'(exp_tt));
    chk({tag, "_match"}, 32'(match_v[k]), 32'(exp_m));
    chk({tag, "_mismatch_cnt"}, 32'(mis_v[k]), 32'(exp_mis));
    start_v[k] = b2b;
    @(negedge clk);
    start_v[k] = 1'b0;
    chk({tag, "_done_one_cycle"}, 32'(done_v[k]), 32'd0);
    if (b2b) chk({tag, "_b2b_busy"}, 32'(busy_v[k]), 32'd1);
  endtask

  typedef struct {
    int          k;
    int          md;
    logic [15:0] tt;
    logic        m;
    logic [4:0]  mis;
    bit          b2b;
    string       name;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [15:0] e;
    int          k;
    int          n;
    checks  = 0;
    errors  = 0;
    s_of    = '{1, 3, 1, 1};
    texp    = '{16'h8888, 16'h8888, 16'h6996, 16'h0000};
    mode    = '{0, 0, 0, 0};
    rtt     = '{16'h0, 16'h0, 16'h0, 16'h0};
    start_v = 4'b0000;

    vecs[0] = '{k: 0, md: 0, tt: 16'h8888, m: 1'b1, mis: 5'd0,  b2b: 1'b0, name: "and_s1"};
    vecs[1] = '{k: 1, md: 1, tt: 16'hFF00, m: 1'b0, mis: 5'd8,  b2b: 1'b0, name: "x3_s3"};
    vecs[2] = '{k: 2, md: 2, tt: 16'h6996, m: 1'b1, mis: 5'd0,  b2b: 1'b1, name: "xor_s1"};
    vecs[3] = '{k: 3, md: 4, tt: 16'hFFFF, m: 1'b0, mis: 5'd16, b2b: 1'b0, name: "one_s1"};

    // Reset state
    rst_n = 1'b0;
    #12;
    chk("rst_x", 32'(xidx_v[0]), 32'd0);
    chk("rst_busy", 32'(busy_v), 32'd0);
    chk("rst_done", 32'(done_v), 32'd0);
    chk("rst_tt", 32'(tt_v[0]), 32'd0);
    chk("rst_match", 32'(match_v), 32'd0);
    chk("rst_mis", 32'(mis_v[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int v = 0; v < 4; v++) begin
      mode[vecs[v].k] = vecs[v].md;
      run_and_check(vecs[v].k, 1'b0, 1'b0, vecs[v].b2b, vecs[v].tt, vecs[v].m, vecs[v].mis, vecs[v].name);
      if (vecs[v].b2b) begin
        // Second sweep started in the done cycle with the network switched to constant 0.
        mode[vecs[v].k] = 3;
        run_and_check(vecs[v].k, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 5'd8, "b2b_zero");
      end
    end

    // Extra start pulses during busy
    mode[0] = 0;
    run_and_check(0, 1'b0, 1'b1, 1'b0, 16'h8888, 1'b1, 5'd0, "extra_start");

    // Asynchronous reset at minterm 7 mid-sweep
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (xidx_v[0] != 4'd7 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_minterm7", 32'(xidx_v[0]), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_x", 32'(xidx_v[0]), 32'd0);
    chk("midrst_busy", 32'(busy_v[0]), 32'd0);
    chk("midrst_done", 32'(done_v[0]), 32'd0);
    chk("midrst_tt", 32'(tt_v[0]), 32'd0);
    chk("midrst_match", 32'(match_v[0]), 32'd0);
    chk("midrst_mis", 32'(mis_v[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized networks against the truth-table model
    for (int r = 0; r < 8; r++) begin
      k = (r % 3 == 2) ? 1 : 0;
      rtt[k]  = (r == 4) ? 16'h8888 : 16'($urandom);
      mode[k] = 5;
      e = ref_tt(5, rtt[k]);
      run_and_check(k, 1'b0, (r == 1), 1'b0, e, (e == texp[k]), 5'($countones(e ^ texp[k])),
                    $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
